// File: rtl/csa_word_sequencer_pkg.sv
// Shared definitions for the slice-serial wide adder.
package csa_word_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Slice counter width; at least one bit even for a single-slice build.
  function automatic int cnt_width(input int words);
    if (words <= 1) return 1;
    return $clog2(words);
  endfunction

endpackage

// File: rtl/csa_word_sequencer_csa.sv
// Combinational conditional-sum adder, N bits wide.
// Every bit position starts with both candidate sums/carries (carry-in 0 and 1).
// Adjacent blocks then merge pairwise, doubling the block size each level.
// The real carry-in picks the final candidate at the very end.
module csa_word_sequencer_csa #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co
);

  localparam int LEVELS = (N > 1) ? $clog2(N) : 0;

  // s0/s1: per-bit sum assuming the enclosing block's carry-in is 0/1.
  // c0/c1: carry-out of the block that starts at that bit index.
  logic [N-1:0] s0, s1, c0, c1;
  logic         t0, t1;

  // Build candidate pairs, merge blocks level by level, then select on ci.
  always_comb begin
    t0 = 1'b0;
    t1 = 1'b0;
    for (int i = 0; i < N; i++) begin
      s0[i] = a[i] ^ b[i];
      s1[i] = ~(a[i] ^ b[i]);
      c0[i] = a[i] & b[i];
      c1[i] = a[i] | b[i];
    end
    for (int lvl = 0; lvl < LEVELS; lvl++) begin
      for (int j = 0; j < N; j++) begin
        if ((j % (2 << lvl)) == 0 && (j + (1 << lvl)) < N) begin
          // Upper half chooses its candidates from the lower half's carry-out.
          for (int k = 0; k < N; k++) begin
            if (k >= j + (1 << lvl) && k < j + (2 << lvl)) begin
              t0 = c0[j] ? s1[k] : s0[k];
              t1 = c1[j] ? s1[k] : s0[k];
              s0[k] = t0;
              s1[k] = t1;
            end
          end
          t0 = c0[j] ? c1[j + (1 << lvl)] : c0[j + (1 << lvl)];
          t1 = c1[j] ? c1[j + (1 << lvl)] : c0[j + (1 << lvl)];
          c0[j] = t0;
          c1[j] = t1;
        end
      end
    end
    sum = ci ? s1 : s0;
    co  = ci ? c1[0] : c0[0];
  end

endmodule

// File: rtl/csa_word_sequencer.sv
// Slice-serial wide adder: one N-bit conditional-sum adder is reused WORDS
// times, least-significant slice first, with the carry held in a register.
// Operands are captured on an accepted start; sum/co only update on completion.
module csa_word_sequencer
  import csa_word_sequencer_pkg::*;
#(
  parameter int N     = 4,
  parameter int WORDS = 4,
  parameter int W     = N * WORDS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         co
);

  localparam int CNT_W = cnt_width(WORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS - 1);

  state_t           state, state_nxt;
  logic [W-1:0]     a_sh, a_sh_nxt;
  logic [W-1:0]     b_sh, b_sh_nxt;
  logic             carry, carry_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [W-1:0]     acc, acc_nxt;
  logic [W-1:0]     sum_nxt;
  logic             co_nxt, busy_nxt, done_nxt;

  logic [N-1:0]     slice_sum;
  logic             slice_co;
  logic [W-1:0]     acc_shift;

  csa_word_sequencer_csa #(.N(N)) u_csa (
    .a   (a_sh[N-1:0]),
    .b   (b_sh[N-1:0]),
    .ci  (carry),
    .sum (slice_sum),
    .co  (slice_co)
  );

  // New slice enters the accumulator from the top; single-slice builds skip acc.
  generate
    if (WORDS > 1) begin : g_acc
      assign acc_shift = {slice_sum, acc[W-1:N]};
    end else begin : g_no_acc
      assign acc_shift = slice_sum;
    end
  endgenerate

  // Next-state and datapath updates for the IDLE/RUN sequencer.
  always_comb begin
    state_nxt = state;
    a_sh_nxt  = a_sh;
    b_sh_nxt  = b_sh;
    carry_nxt = carry;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    sum_nxt   = sum;
    co_nxt    = co;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          a_sh_nxt  = a;
          b_sh_nxt  = b;
          carry_nxt = ci;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_nxt   = acc_shift;
        a_sh_nxt  = a_sh >> N;
        b_sh_nxt  = b_sh >> N;
        carry_nxt = slice_co;
        cnt_nxt   = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          sum_nxt   = acc_shift;
          co_nxt    = slice_co;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      sum   <= '0;
      co    <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      a_sh  <= a_sh_nxt;
      b_sh  <= b_sh_nxt;
      carry <= carry_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      sum   <= sum_nxt;
      co    <= co_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_csa_word_sequencer.sv
// Directed bench for the slice-serial wide adder with a transaction-level model.
module tb_csa_word_sequencer;

  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic         clk = 1'b0;
  logic         reset, start, ci;
  logic [W-1:0] a, b;
  logic         busy, done, co;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;

  csa_word_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ci    (ci),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Model: full-width addition computed at acceptance, released WORDS edges later.
  logic         m_busy = 1'b0, m_done = 1'b0, m_co = 1'b0, m_valid = 1'b0;
  logic [W-1:0] m_sum = '0;
  logic [W:0]   m_pending = '0;
  int           m_left = 0;

  // Advance the model on every rising edge.
  always @(posedge clk) begin
    if (reset) begin
      m_busy  = 1'b0;
      m_done  = 1'b0;
      m_sum   = '0;
      m_co    = 1'b0;
      m_left  = 0;
      m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start) begin
          m_pending = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
          m_left    = WORDS;
          m_busy    = 1'b1;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_sum  = m_pending[W-1:0];
          m_co   = m_pending[W];
          m_done = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  // Compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("sum",  32'(sum),  32'(m_sum));
      check("co",   32'(co),   32'(m_co));
    end
  end

  task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
    start = 1'b1;
    a     = av;
    b     = bv;
    ci    = cv;
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic [W-1:0] exp_sum, input logic exp_co);
    logic got;
    got = 1'b0;
    launch(av, bv, cv);
    for (int i = 0; i < 20 && !got; i++) begin
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check({name, "_done_seen"}, 32'(got), 32'd1);
    check({name, "_sum"}, 32'(sum), 32'(exp_sum));
    check({name, "_co"}, 32'(co), 32'(exp_co));
    @(negedge clk);
  endtask

  initial begin
    int done_at, n_done, n_busy;
    reset = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    ci    = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_co",   32'(co),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic op with latency tracking: busy after edges 0..3, done after edge 4.
    launch(16'h1234, 16'h4321, 1'b0);
    done_at = -1; n_done = 0; n_busy = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (done && done_at < 0) done_at = i;
      if (done) n_done++;
      if (busy) n_busy++;
    end
    check("lat_done_edge", 32'(done_at), 32'd4);
    check("lat_busy_cycles", 32'(n_busy), 32'd4);
    check("lat_done_count", 32'(n_done), 32'd1);
    check("basic_sum", 32'(sum), 32'h5555);
    check("basic_co", 32'(co), 32'd0);

    run_op("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    run_op("allones", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    run_op("zeros", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);

    // Starts during an op are ignored.
    launch(16'h1234, 16'h4321, 1'b0);
    start = 1'b1; a = 16'hAAAA; b = 16'hAAAA;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0; a = '0; b = '0;
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("ign_done_count", 32'(n_done), 32'd1);
    check("ign_sum", 32'(sum), 32'h5555);
    check("ign_busy", 32'(busy), 32'd0);

    // Reset mid-operation aborts without a done pulse.
    launch(16'h8000, 16'h8000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_co", 32'(co), 32'd0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) n_done++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(n_done), 32'd0);
    run_op("after_abort", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);

    // Start held high: one completion every WORDS+1 cycles.
    start = 1'b1; a = 16'h0001; b = 16'h0001; ci = 1'b0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    start = 1'b0;
    check("stream_done_count", 32'(n_done), 32'd4);
    check("stream_sum", 32'(sum), 32'h0002);
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
